cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides, carry-in, and status flags (carry-out, signed overflow, zero). It extends the team's fixed 32-bit combinational CLA with four additions: configurable width, group size and pipeline depth; a subtract mode; backpressure; and optional saturation. It sits between an operand-issue stage and a result-writeback stage in the ALU datapath.

---
 rtl/cla_pipe_addsub.sv | 193 +++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional signed saturation is compiled in when CLA_SAT_EN is defined.
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / GROUP;
    localparam int LAST  = STAGES - 1;

    // Per-stage registered state; stage LAST is the output register set.
    logic             v_r    [STAGES];
    logic [WIDTH-1:0] a_r    [STAGES];
    logic [WIDTH-1:0] b_r    [STAGES];
    logic [WIDTH-1:0] s_r    [STAGES];
    logic             c_r    [STAGES];
    logic             ovf_r  [STAGES];
    logic             zero_r [STAGES];

    // Inputs seen by each stage's slice logic (ports for stage 0).
    logic             src_v_s [STAGES];
    logic [WIDTH-1:0] src_a_s [STAGES];
    logic [WIDTH-1:0] src_b_s [STAGES];
    logic [WIDTH-1:0] src_s_s [STAGES];
    logic             src_c_s [STAGES];

    logic [WIDTH-1:0] nxt_s_s    [STAGES];
    logic             nxt_c_s    [STAGES];
    logic             nxt_ovf_s  [STAGES];
    logic             nxt_zero_s [STAGES];
    logic             ld_s       [STAGES];

`ifdef CLA_SAT_EN
    logic             sat_r     [STAGES];
    logic             src_sat_s [STAGES];
`else
    logic             unused_sat_s;
    assign unused_sat_s = sat;
`endif

    // Returns {carry out of slice, carry into slice MSB, slice sum}.
    function automatic logic [SLICE+1:0] cla_slice(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             ci
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        logic [NGRP:0]    gc;
        logic             gg;
        logic             gp;
        g     = x & y;
        p     = x ^ y;
        gc[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                gp = gp & p[j*GROUP+i];
            end
            gc[j+1] = gg | (gp & gc[j]);
        end
        // Bit carries inside each group start from the lookahead group carry.
        for (int j = 0; j < NGRP; j++) begin
            c[j*GROUP] = gc[j];
            for (int i = 0; i < GROUP - 1; i++) begin
                c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
            end
        end
        c[SLICE] = gc[NGRP];
        return {c[SLICE], c[SLICE-1], p ^ c[SLICE-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] sat_extreme(input logic msb);
        return msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // Route the ports into stage 0 and each stage register into its successor.
    always_comb begin
        src_v_s[0] = in_valid;
        src_a_s[0] = a;
        src_b_s[0] = sub ? ~b : b;
        src_s_s[0] = '0;
        src_c_s[0] = cin ^ sub;
`ifdef CLA_SAT_EN
        src_sat_s[0] = sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_v_s[k] = v_r[k-1];
            src_a_s[k] = a_r[k-1];
            src_b_s[k] = b_r[k-1];
            src_s_s[k] = s_r[k-1];
            src_c_s[k] = c_r[k-1];
`ifdef CLA_SAT_EN
            src_sat_s[k] = sat_r[k-1];
`endif
        end
    end

    // Slice k is resolved in stage k; flags and saturation only in the last stage.
    always_comb begin
        logic [SLICE+1:0] res_s;
        for (int k = 0; k < STAGES; k++) begin
            res_s      = cla_slice(src_a_s[k][k*SLICE +: SLICE],
                                   src_b_s[k][k*SLICE +: SLICE], src_c_s[k]);
            nxt_s_s[k] = src_s_s[k];
            nxt_s_s[k][k*SLICE +: SLICE] = res_s[SLICE-1:0];
            nxt_c_s[k] = res_s[SLICE+1];
            if (k == LAST) begin
                nxt_ovf_s[k] = res_s[SLICE+1] ^ res_s[SLICE];
`ifdef CLA_SAT_EN
                nxt_s_s[k] = (src_sat_s[k] && nxt_ovf_s[k])
                           ? sat_extreme(src_a_s[k][WIDTH-1]) : nxt_s_s[k];
`endif
                nxt_zero_s[k] = (nxt_s_s[k] == {WIDTH{1'b0}});
            end else begin
                nxt_ovf_s[k]  = 1'b0;
                nxt_zero_s[k] = 1'b0;
            end
        end
    end

    // A stage loads when empty or when its beat moves on this cycle.
    always_comb begin
        ld_s[LAST] = !v_r[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            ld_s[k] = !v_r[k] || ld_s[k+1];
        end
    end

    // Stage registers; payload only captured with a valid beat so outputs hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k]    <= 1'b0;
                a_r[k]    <= '0;
                b_r[k]    <= '0;
                s_r[k]    <= '0;
                c_r[k]    <= 1'b0;
                ovf_r[k]  <= 1'b0;
                zero_r[k] <= 1'b0;
`ifdef CLA_SAT_EN
                sat_r[k]  <= 1'b0;
`endif
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld_s[k]) begin
                    v_r[k] <= src_v_s[k];
                    if (src_v_s[k]) begin
                        a_r[k]    <= src_a_s[k];
                        b_r[k]    <= src_b_s[k];
                        s_r[k]    <= nxt_s_s[k];
                        c_r[k]    <= nxt_c_s[k];
                        ovf_r[k]  <= nxt_ovf_s[k];
                        zero_r[k] <= nxt_zero_s[k];
`ifdef CLA_SAT_EN
                        sat_r[k]  <= src_sat_s[k];
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = ld_s[0];
    assign out_valid = v_r[LAST];
    assign sum       = s_r[LAST];
    assign cout      = c_r[LAST];
    assign ovf       = ovf_r[LAST];
    assign zero      = zero_r[LAST];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench: directed cases on a 32-bit/2-stage instance and a
// randomized regression on a 16-bit/4-stage instance, both against a model.
module tb_cla_pipe_addsub;

    localparam int S32 = 2;
    localparam int S16 = 4;
`ifdef CLA_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
        bit          exact;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, or32, cin32, sub32, sat32, cout32, ovf32, zero32;
    logic [31:0] a32, b32, sum32;
    logic        iv16, ir16, ov16, or16, cin16, sub16, sat16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, sum16;

    int   checks_cnt   = 0;
    int   failures_cnt = 0;
    int   cyc          = 0;
    bit   exact_lat    = 1'b0;
    int   pop32        = 0;
    int   pop16        = 0;
    int   acc16        = 0;
    exp_t q32[$];
    exp_t q16[$];

    cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(S32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32), .sat(sat32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4), .STAGES(S16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .sat(sat16),
        .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int w, input longint unsigned av, input longint unsigned bv,
                                   input logic ci, input logic sb, input logic st);
        exp_t              e;
        longint unsigned   m, half, u;
        longint            sa, sbv, sr;
        m    = 64'd1 << w;
        half = m >> 1;
        sa   = longint'(av);
        sbv  = longint'(bv);
        if (av >= half) sa  = sa - longint'(m);
        if (bv >= half) sbv = sbv - longint'(m);
        if (!sb) begin
            u      = av + bv + 64'(ci);
            e.cout = (u >= m);
            sr     = sa + sbv + longint'(ci);
        end else begin
            e.cout = (av >= bv + 64'(ci));
            u      = av - bv - 64'(ci);
            sr     = sa - sbv - longint'(ci);
        end
        u     = u & (m - 64'd1);
        e.ovf = (sr >= longint'(half)) || (sr < -longint'(half));
        e.sum = u[31:0];
        if (SAT_BUILD && st && e.ovf) begin
            u     = (sa < 0) ? half : half - 64'd1;
            e.sum = u[31:0];
        end
        e.zero  = (e.sum == 32'd0);
        e.cyc   = cyc;
        e.exact = exact_lat;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the 32-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
        end else begin
            if (q32.size() == 0) begin
                check_eq("d32_no_stale", 64'(ov32), 64'd0);
            end else if (ov32) begin
                check_eq("d32_sum",  64'(sum32),  64'(q32[0].sum));
                check_eq("d32_cout", 64'(cout32), 64'(q32[0].cout));
                check_eq("d32_ovf",  64'(ovf32),  64'(q32[0].ovf));
                check_eq("d32_zero", 64'(zero32), 64'(q32[0].zero));
                if (q32[0].exact) check_eq("d32_latency", 64'(cyc - q32[0].cyc), 64'(S32));
                else check_eq("d32_min_latency", 64'((cyc - q32[0].cyc) >= S32), 64'd1);
                if (or32) begin
                    void'(q32.pop_front());
                    pop32++;
                end
            end
            if (iv32 && ir32) q32.push_back(model(32, 64'(a32), 64'(b32), cin32, sub32, sat32));
        end
    end

    // Scoreboard for the 16-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
        end else begin
            if (q16.size() == 0) begin
                check_eq("d16_no_stale", 64'(ov16), 64'd0);
            end else if (ov16) begin
                check_eq("d16_sum",  64'(sum16),  64'(q16[0].sum));
                check_eq("d16_cout", 64'(cout16), 64'(q16[0].cout));
                check_eq("d16_ovf",  64'(ovf16),  64'(q16[0].ovf));
                check_eq("d16_zero", 64'(zero16), 64'(q16[0].zero));
                check_eq("d16_min_latency", 64'((cyc - q16[0].cyc) >= S16), 64'd1);
                if (or16) begin
                    void'(q16.pop_front());
                    pop16++;
                end
            end
            if (iv16 && ir16) begin
                q16.push_back(model(16, 64'(a16), 64'(b16), cin16, sub16, sat16));
                acc16++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send32(input logic [31:0] av, input logic [31:0] bv,
                          input logic c, input logic s, input logic t);
        bit acc;
        acc   = 1'b0;
        a32   = av;
        b32   = bv;
        cin32 = c;
        sub32 = s;
        sat32 = t;
        iv32  = 1'b1;
        for (int i = 0; i < 16 && !acc; i++) begin
            @(negedge clk);
            acc = ir32;
            @(posedge clk);
            #2;
        end
        iv32 = 1'b0;
        if (!acc) check_eq("d32_send_timeout", 64'(acc), 64'd1);
    endtask

    function automatic logic [15:0] pick16();
        logic [15:0] r;
        case ($urandom_range(0, 7))
            0:       r = 16'h0000;
            1:       r = 16'hFFFF;
            2:       r = 16'h7FFF;
            3:       r = 16'h8000;
            default: r = 16'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        int pre;
        rst_n = 1'b0;
        iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; sat32 = 1'b0;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; sat16 = 1'b0;
        step(3);
        check_eq("rst_out_valid", 64'(ov32),   64'd0);
        check_eq("rst_sum",       64'(sum32),  64'd0);
        check_eq("rst_cout",      64'(cout32), 64'd0);
        check_eq("rst_ovf",       64'(ovf32),  64'd0);
        check_eq("rst_zero",      64'(zero32), 64'd0);
        check_eq("rst_in_ready",  64'(ir32),   64'd1);
        check_eq("rst16_out_valid", 64'(ov16), 64'd0);
        check_eq("rst16_in_ready",  64'(ir16), 64'd1);
        rst_n = 1'b1;
        step(1);

        // Carry-out and zero, with exact latency.
        exact_lat = 1'b1;
        send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step(S32 - 1);
        check_eq("co_valid", 64'(ov32),   64'd1);
        check_eq("co_sum",   64'(sum32),  64'd0);
        check_eq("co_cout",  64'(cout32), 64'd1);
        check_eq("co_ovf",   64'(ovf32),  64'd0);
        check_eq("co_zero",  64'(zero32), 64'd1);
        step(2);

        // Signed overflow, with and without sat requested.
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step(S32 - 1);
        check_eq("ovf_sat_sum", 64'(sum32), SAT_BUILD ? 64'h7FFF_FFFF : 64'h8000_0000);
        check_eq("ovf_sat_ovf", 64'(ovf32), 64'd1);
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step(S32 - 1);
        check_eq("ovf_wrap_sum", 64'(sum32), 64'h8000_0000);
        send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        step(2);

        // Subtract with and without borrow-in.
        send32(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
        step(S32 - 1);
        check_eq("sub_sum",  64'(sum32),  64'hFFFF_FFFE);
        check_eq("sub_cout", 64'(cout32), 64'd0);
        check_eq("sub_zero", 64'(zero32), 64'd0);
        send32(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        step(S32 - 1);
        check_eq("subb_sum", 64'(sum32), 64'hFFFF_FFFD);
        send32(32'd9, 32'd8, 1'b1, 1'b1, 1'b0);
        step(2);
        exact_lat = 1'b0;

        // Backpressure: two beats fill the pipe, then drain one per cycle.
        or32 = 1'b0;
        send32(32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        send32(32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        a32 = 32'd3; b32 = 32'd3; iv32 = 1'b1;
        #1;
        check_eq("bp_in_ready_low", 64'(ir32), 64'd0);
        check_eq("bp_hold_sum",     64'(sum32), 64'd2);
        step(2);
        check_eq("bp_in_ready_still", 64'(ir32), 64'd0);
        check_eq("bp_hold_sum2",      64'(sum32), 64'd2);
        pre  = pop32;
        or32 = 1'b1;
        step(1);
        a32 = 32'd4; b32 = 32'd4;
        step(1);
        iv32 = 1'b0;
        step(2);
        check_eq("bp_drain_count", 64'(pop32 - pre), 64'd4);

        // Reset with two beats in flight.
        or32 = 1'b0;
        send32(32'd10, 32'd20, 1'b0, 1'b0, 1'b0);
        send32(32'd30, 32'd40, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1);
        check_eq("mid_rst_out_valid", 64'(ov32),  64'd0);
        check_eq("mid_rst_sum",       64'(sum32), 64'd0);
        check_eq("mid_rst_in_ready",  64'(ir32),  64'd1);
        rst_n = 1'b1;
        or32  = 1'b1;
        step(6);

        // Randomized regression on the 4-stage instance.
        for (int i = 0; i < 800; i++) begin
            iv16  = ($urandom_range(0, 9) < 7);
            a16   = pick16();
            b16   = pick16();
            cin16 = 1'($urandom);
            sub16 = 1'($urandom);
            sat16 = 1'($urandom);
            or16  = ($urandom_range(0, 9) < 6);
            step(1);
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        step(3 * S16);
        check_eq("d16_result_count", 64'(pop16), 64'(acc16));
        check_eq("d16_queue_empty",  64'(q16.size()), 64'd0);
        check_eq("d16_accepted_some", 64'(acc16 > 100), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
